// File: rtl/life_ctrl_pkg.sv
// life_ctrl_pkg: shared types, sizes and cell indexing for the life controller
package life_ctrl_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CELLS = ROWS * COLS;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(r * COLS + c);
  endfunction
endpackage

// File: rtl/life_ctrl_sequencer_divider.sv
// frame_rate_divider: counts frame pulses while running and requests a generation every max(rate,1) frames
module frame_rate_divider #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame,
  input  logic              running,
  input  logic [RATE_W-1:0] rate,
  output logic              gen_req
);
  logic [RATE_W-1:0] count;
  logic [RATE_W-1:0] last;
  assign last = (rate == '0) ? '0 : rate - 1'b1;
  assign gen_req = running && frame && count >= last;
  // held at zero while paused so every entry into run starts a fresh period
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (!running) count <= '0;
    else if (frame) count <= gen_req ? '0 : count + 1'b1;
endmodule

// File: rtl/life_ctrl_sequencer.sv
// life_ctrl_sequencer: arbitrates cursor edits, clears and generation advances on the cell array write port
module life_ctrl_sequencer
  import life_ctrl_pkg::*;
#(
  parameter int RATE_W = 8,
  parameter int GEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame,
  input  logic [15:0]       alive,
  input  logic [RATE_W-1:0] rate,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_toggle,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_clear,
  output logic [1:0]        row,
  output logic [1:0]        col,
  output logic              val,
  output logic              write_enb,
  output logic              run,
  output logic [1:0]        cursor_row,
  output logic [1:0]        cursor_col,
  output logic              running,
  output logic              busy,
  output logic [GEN_W-1:0]  gen_count
);
  state_t state, state_nxt;
  logic clr_p, tog_p, gen_p, gen_req;
  logic svc_clr, svc_tog, svc_gen;
  logic [1:0] tog_row, tog_col, row_nxt, col_nxt, row_step, col_step;
  logic [3:0] idx, idx_nxt;
  logic val_nxt, we_nxt, run_nxt;
  frame_rate_divider #(.RATE_W(RATE_W)) u_div (
    .clk(clk), .reset(reset), .frame(frame), .running(running), .rate(rate), .gen_req(gen_req)
  );
  assign svc_clr = state == IDLE && clr_p;
  assign svc_tog = state == IDLE && !clr_p && tog_p;
  assign svc_gen = state == IDLE && !clr_p && !tog_p && gen_p;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state == IDLE ? (clr_p ? CLEAR : tog_p ? WRITE : IDLE)
              : (state == CLEAR && idx != 4'd15) ? CLEAR : IDLE;
  end
  // outputs are computed for the upcoming state and registered alongside it
  always_comb begin
    idx_nxt = state == CLEAR ? idx + 4'd1 : 4'd0;
    we_nxt  = state_nxt != IDLE;
    run_nxt = svc_gen;
    row_nxt = state_nxt == WRITE ? tog_row : state_nxt == CLEAR ? idx_nxt[3:2] : row;
    col_nxt = state_nxt == WRITE ? tog_col : state_nxt == CLEAR ? idx_nxt[1:0] : col;
    val_nxt = state_nxt == WRITE ? ~alive[cell_idx(tog_row, tog_col)] : 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      row       <= '0;
      col       <= '0;
      val       <= 1'b0;
      write_enb <= 1'b0;
      run       <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      val       <= val_nxt;
      write_enb <= we_nxt;
      run       <= run_nxt;
    end
  assign row_step = (btn_down && !btn_up) ? 2'd1 : (btn_up && !btn_down) ? 2'd3 : 2'd0;
  assign col_step = (btn_right && !btn_left) ? 2'd1 : (btn_left && !btn_right) ? 2'd3 : 2'd0;
  // a pending flag drops new requests until it is serviced
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      clr_p      <= 1'b0;
      tog_p      <= 1'b0;
      gen_p      <= 1'b0;
      tog_row    <= '0;
      tog_col    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      running    <= 1'b0;
      gen_count  <= '0;
    end else begin
      cursor_row <= cursor_row + row_step;
      cursor_col <= cursor_col + col_step;
      running    <= running ^ btn_run;
      clr_p      <= clr_p ? !svc_clr : btn_clear;
      tog_p      <= tog_p ? !(svc_tog || svc_clr) : btn_toggle;
      gen_p      <= gen_p ? !(svc_gen || svc_clr) : ((btn_step && !running) || gen_req);
      gen_count  <= svc_clr ? '0 : svc_gen ? gen_count + 1'b1 : gen_count;
      if (!tog_p && btn_toggle) begin
        tog_row <= cursor_row;
        tog_col <= cursor_col;
      end
    end
endmodule

// File: tb/tb_life_ctrl_sequencer.sv
// tb_life_ctrl_sequencer: directed self-checking bench for life_ctrl_sequencer
module tb_life_ctrl_sequencer;
  logic clk = 0, reset = 1, frame = 0;
  logic [15:0] alive = '0;
  logic [7:0] rate = 8'd3;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic btn_toggle = 0, btn_run = 0, btn_step = 0, btn_clear = 0;
  logic [1:0] row, col, cursor_row, cursor_col;
  logic val, write_enb, run, running, busy;
  logic [15:0] gen_count;
  int total = 0, bad = 0, seen;
  life_ctrl_sequencer #(.RATE_W(8), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .frame(frame), .alive(alive), .rate(rate),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_toggle(btn_toggle), .btn_run(btn_run), .btn_step(btn_step), .btn_clear(btn_clear),
    .row(row), .col(col), .val(val), .write_enb(write_enb), .run(run),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .running(running), .busy(busy),
    .gen_count(gen_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      total++;
      assert (!(write_enb && run)) else begin
        bad++;
        $error("FAIL overlap observed=%0b%0b expected=not both", write_enb, run);
      end
    end
  initial begin
    repeat (2) tick;
    chk("rst_cursor", {cursor_row, cursor_col}, 4'h0);
    chk("rst_outs", {row, col, val, write_enb, run, running, busy}, 0);
    chk("rst_gen", gen_count, 0);
    reset = 0;
    tick;
    for (int i = 0; i < 4; i++) begin
      btn_right = 1; tick; btn_right = 0;
    end
    btn_up = 1; tick; btn_up = 0;
    chk("cursor_wrap", {cursor_row, cursor_col}, {2'd3, 2'd0});
    {btn_up, btn_down, btn_left, btn_right} = 4'hF; tick; {btn_up, btn_down, btn_left, btn_right} = 4'h0;
    chk("cursor_cancel", {cursor_row, cursor_col}, {2'd3, 2'd0});
    for (int i = 0; i < 2; i++) begin
      btn_down = 1; btn_right = 1; tick; btn_down = 0; btn_right = 0;
    end
    chk("cursor_12", {cursor_row, cursor_col}, {2'd1, 2'd2});
    btn_toggle = 1; tick; btn_toggle = 0;
    chk("tog_c1", write_enb, 0);
    tick;
    chk("tog_c2", {write_enb, row, col, val, run, busy}, {1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1});
    tick;
    chk("tog_c3", {write_enb, busy}, 2'b00);
    btn_run = 1; tick; btn_run = 0;
    chk("run_on", running, 1);
    for (int k = 1; k <= 9; k++) begin
      frame = 1; tick; frame = 0;
      seen = 0;
      repeat (3) begin
        if (run) seen++;
        tick;
      end
      chk($sformatf("rate3_f%0d", k), seen, (k % 3 == 0) ? 1 : 0);
    end
    chk("gen_after9", gen_count, 3);
    btn_step = 1; tick; btn_step = 0;
    seen = 0;
    repeat (4) begin
      if (run) seen++;
      tick;
    end
    chk("step_running", seen, 0);
    rate = 8'd0;
    for (int k = 1; k <= 2; k++) begin
      frame = 1; tick; frame = 0;
      seen = 0;
      repeat (3) begin
        if (run) seen++;
        tick;
      end
      chk($sformatf("rate0_f%0d", k), seen, 1);
    end
    chk("gen_rate0", gen_count, 5);
    btn_run = 1; tick; btn_run = 0;
    chk("run_off", running, 0);
    btn_step = 1; tick; btn_step = 0;
    chk("step_c1", run, 0);
    tick;
    chk("step_c2", run, 1);
    tick;
    chk("step_c3", run, 0);
    chk("gen_step", gen_count, 6);
    btn_clear = 1; tick; btn_clear = 0; btn_toggle = 1;
    chk("clr_c1", {write_enb, busy}, 2'b00);
    tick; btn_toggle = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("clr_w%0d", i), {write_enb, busy, row, col, val}, {1'b1, 1'b1, 4'(i), 1'b0});
      tick;
    end
    chk("clr_end", write_enb, 0);
    chk("clr_gen", gen_count, 0);
    seen = 0;
    repeat (4) begin
      if (write_enb && seen == 0) begin
        seen = 1;
        chk("clr_tog", {row, col, val}, {2'd1, 2'd2, 1'b1});
      end
      tick;
    end
    chk("clr_tog_seen", seen, 1);
    btn_toggle = 1; btn_step = 1; tick; btn_toggle = 0; btn_step = 0;
    tick;
    chk("both_write", {write_enb, run}, 2'b10);
    seen = 0;
    repeat (4) begin
      tick;
      if (run) seen++;
    end
    chk("both_run", seen, 1);
    chk("both_gen", gen_count, 1);
    btn_clear = 1; tick; btn_clear = 0;
    tick;
    repeat (7) tick;
    chk("mid_clr7", {write_enb, row, col}, {1'b1, 2'd1, 2'd3});
    reset = 1;
    #1;
    chk("async_rst", {write_enb, busy, run, running}, 4'b0000);
    chk("async_rst_gen", gen_count, 0);
    tick;
    reset = 0;
    tick;
    chk("post_rst", {write_enb, busy}, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/life_ctrl_sequencer.md
Name: life_ctrl_sequencer

Overview:
- Sequences the 4x4 life cell array.
- Owns the array's single write port (row, col, val, write_enb) and its generation-advance strobe (run).
- Arbitrates user edits (cursor toggle, clear) against generation advances, so a write and a run never occur in the same cycle.
- Generation advances are aligned to the VGA frame pulse and paced by a programmable frames-per-generation rate. The block replaces the free-running second timer.

Parameters:
- ROWS, 4, array rows (row index width = 2)
- COLS, 4, array columns (col index width = 2)
- RATE_W, 8, width of rate input and frame counter
- GEN_W, 16, width of generation counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame  in  1  one-cycle pulse per video frame, from the VESA driver
- alive  in  16  current cell states, index = row*4+col
- rate  in  RATE_W  frames per generation; 0 is treated as 1
- btn_up, btn_down, btn_left, btn_right  in  1 each  cursor move pulses, pre-debounced, one cycle
- btn_toggle  in  1  invert the cell under the cursor
- btn_run  in  1  toggle run/pause
- btn_step  in  1  single generation while paused
- btn_clear  in  1  zero all cells
- row  out  2  array write row
- col  out  2  array write column
- val  out  1  array write value
- write_enb  out  1  array write strobe
- run  out  1  one-cycle generation advance strobe
- cursor_row  out  2  cursor position, for overlay
- cursor_col  out  2  cursor position, for overlay
- running  out  1  1 = free-run mode
- busy  out  1  FSM not in IDLE
- gen_count  out  GEN_W  generations advanced since reset or clear

Behaviour:
- Reset (async) values:
  - FSM = IDLE; all pending flags 0.
  - cursor = (0,0); running = 0; frame counter = 0; gen_count = 0.
  - row = col = val = write_enb = run = 0.
- Reset mid-clear aborts the clear immediately. Cells already written stay written.
- Cursor:
  - Moves are accepted every cycle, including while busy.
  - Up/down change row by -1/+1; left/right change col by -1/+1. All moves wrap modulo 4.
  - Simultaneous up+down cancels on the row axis; simultaneous left+right cancels on the col axis.
- Request latches (one-deep, set on the button pulse, cleared when serviced):
  - clr_p: set by btn_clear.
  - tog_p: set by btn_toggle; captures cursor {row,col} in the same cycle. A second toggle while tog_p is set is dropped.
  - gen_p: set by btn_step while running=0 (ignored while running); also set by the rate divider.
- Rate divider:
  - Active only while running=1.
  - On each frame pulse: if count >= max(rate,1)-1, set count = 0 and set gen_p; otherwise count+1.
  - A new request while gen_p is already set is dropped; requests do not accumulate.
- Run/pause:
  - btn_run toggles running.
  - Entering run clears the frame counter.
  - Entering pause does not clear a gen_p that is already pending; it is still serviced.
- FSM states: IDLE, WRITE, CLEAR.
  - IDLE priority: clr_p > tog_p > gen_p.
  - clr_p in IDLE: go to CLEAR with idx = 0; clear clr_p, tog_p and gen_p; set gen_count = 0.
  - tog_p in IDLE: go to WRITE.
  - gen_p in IDLE: assert run for exactly one cycle in the next cycle; gen_count+1, wrapping; clear gen_p; stay in IDLE.
  - WRITE (one cycle):
    - write_enb = 1; {row,col} = captured cursor; val = ~alive[captured index], sampled when WRITE is entered.
    - Next state is IDLE.
  - CLEAR (16 cycles):
    - write_enb = 1; row = idx[3:2]; col = idx[1:0]; val = 0; idx+1.
    - After idx = 15, go to IDLE.
    - Requests arriving during CLEAR are latched and serviced afterwards. A btn_clear during CLEAR re-arms clr_p.
- Output timing and invariants:
  - All outputs are registered.
  - Latency from button pulse to first write_enb or run is 2 cycles: latch, then IDLE decision.
  - write_enb and run are never both 1.
  - busy = (state != IDLE).

Decomposition:
- Package life_ctrl_pkg holds:
  - state enum {IDLE, WRITE, CLEAR};
  - constants ROWS, COLS, CELLS = 16;
  - function cell_idx(row,col) = row*COLS + col.
- Sub-module frame_rate_divider holds the frame counter, rate clamp and gen-request output, gated by running.

Test Plan:
- Reset, 4x btn_right, 1x btn_up -> cursor = (3,0).
- Cursor (1,2), alive=0, btn_toggle -> one cycle with write_enb=1, row=1, col=2, val=1, 2 cycles after the pulse; run stays 0.
- running=1, rate=3, 9 frame pulses -> exactly 3 run pulses, each 1 cycle after the 3rd/6th/9th frame; gen_count=3.
- btn_clear then btn_toggle the next cycle -> 16 consecutive writes with val=0 at idx 0..15, then the toggle write; gen_count=0.
- Paused, btn_step -> one run pulse. Running, btn_step -> no extra run.
- Toggle and due generation in the same cycle -> write first, run the following cycle, never overlapped. Reset asserted at CLEAR idx=7 -> write_enb=0 immediately, state IDLE.
